alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port load_btn, input, 1, program-write request; level input, rising edge detected internally.
REQ-004 SHALL have port run_btn, input, 1, start-program request; level input, rising edge detected internally.
REQ-005 SHALL have port clr_btn, input, 1, program-clear request; level input, rising edge detected internally.
REQ-006 SHALL have port A_in, input, 3, initial accumulator value, sampled at run start.
REQ-007 SHALL have port B_in, input, 3, immediate operand written on load.
REQ-008 SHALL have port S_in, input, 3, opcode written on load.
REQ-009 SHALL have port alu_A, output, 3, ALU operand A; driven by acc.
REQ-010 SHALL have port alu_B, output, 3, ALU operand B; driven by the current entry immediate.
REQ-011 SHALL have port alu_S, output, 3, ALU select; driven by the current entry opcode.
REQ-012 SHALL have port alu_out, input, 3, ALU result.
REQ-013 SHALL have port alu_flags, input, 4, ALU flags {Negative, Overflow, C_Out, Zero}.
REQ-014 SHALL have port acc, output, 3, accumulator, for the 7-segment display.
REQ-015 SHALL have port flags, output, 4, registered flags of the last executed entry.
REQ-016 SHALL have port count, output, 3, number of stored entries, 0..4.
REQ-017 SHALL have port busy, output, 1, high while executing.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after the last entry is written.
REQ-019 SHALL have port err, output, 1, sticky error flag.

Function
REQ-020 SHALL store the program in 4 entries of {op[2:0], imm[2:0]}; a load edge in IDLE writes {S_in,B_in} at index count, then increments count.
REQ-021 SHALL ignore a load edge when count==4 and SHALL set err; a load edge while busy is ignored and sets err.
REQ-022 SHALL, on a clr edge in IDLE, set count=0 and err=0; entry contents are don't-care.
REQ-023 SHALL use FSM states IDLE, EXEC, WRITE, DONE.
REQ-024 IDLE->EXEC on a run edge with count>0: acc<=A_in, idx<=0, busy=1. A run edge with count==0 SHALL set err and stay in IDLE.
REQ-025 EXEC: SHALL present alu_A=acc, alu_B=imm[idx], alu_S=op[idx]; next state WRITE.
REQ-026 WRITE: acc<=alu_out, flags<=alu_flags; if idx==count-1 go to DONE, else idx<=idx+1 and go to EXEC.
REQ-027 DONE: done=1 for one cycle, busy=0, then IDLE; acc and flags hold.
REQ-028 Latency: 2 cycles per entry; a program of N entries SHALL assert done 2N+1 cycles after the run-edge cycle.
REQ-029 Each button edge detector SHALL produce exactly one pulse per 0->1 transition; a held level SHALL NOT repeat.
REQ-030 Simultaneous edges in IDLE: priority is clr > run > load; the lower-priority edges are dropped.
REQ-031 Run, load and clr edges while busy: run and clr are ignored; load sets err per REQ-021.
REQ-032 alu_A/B/S SHALL be registered-state-derived only (no combinational path from buttons).

Reset
REQ-033 On rst_n low SHALL asynchronously force state=IDLE, acc=0, flags=0, count=0, idx=0, busy=0, done=0, err=0, and clear the edge-detector history; reset mid-run SHALL abort without a done pulse.

Structure
REQ-034 SHALL place the state encoding, PROG_DEPTH=4, and the data/opcode width (3) in shared package alu_seq_pkg.
REQ-035 SHALL use one sub-module, edge_pulse (rising-edge detector), instantiated three times; the ALU is instantiated outside this block.

Verification
REQ-036 Load {000,2},{000,3}, A_in=1, run; bench ALU model has S=000 as A+B mod 8 -> acc=3 then 6; done at cycle 5 after the run edge; flags Zero=0.
REQ-037 Five load edges -> count=4, err=1; clr -> count=0, err=0.
REQ-038 Run with count=0 -> err=1, busy stays 0, no done.
REQ-039 Load {000,7}, A_in=1, run -> acc=0, flags Zero=1, C_Out=1.
REQ-040 Assert rst_n low during the second EXEC of a 3-entry run -> all outputs 0, no done pulse; run_btn held high for 10 cycles -> only one program execution.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, program depth, FSM encoding and entry type for alu_seq
package alu_seq_pkg;

    localparam int PROG_DEPTH = 4;
    localparam int DATA_W     = 3;
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 3;
    localparam int FLAG_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] op;
        logic [DATA_W-1:0] imm;
    } entry_t;

endpackage

// File: rtl/alu_seq_edge.sv
// rtl/alu_seq_edge.sv - registered rising-edge detector, one pulse per 0->1 transition
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    // Registered pulse keeps button levels off any combinational output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            pulse_q <= level_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - button-driven 4-entry program sequencer around an external 3-bit ALU
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_btn,
    input  logic              run_btn,
    input  logic              clr_btn,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic [DATA_W-1:0] S_in,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [DATA_W-1:0] alu_S,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [DATA_W-1:0] acc,
    output logic [FLAG_W-1:0] flags,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic load_p;
    logic run_p;
    logic clr_p;

    edge_pulse u_load_edge (.clk(clk), .rst_n(rst_n), .level_i(load_btn), .pulse_o(load_p));
    edge_pulse u_run_edge  (.clk(clk), .rst_n(rst_n), .level_i(run_btn),  .pulse_o(run_p));
    edge_pulse u_clr_edge  (.clk(clk), .rst_n(rst_n), .level_i(clr_btn),  .pulse_o(clr_p));

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    entry_t            prog_q [PROG_DEPTH];
    entry_t            prog_d [PROG_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) begin
                prog_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            prog_q  <= prog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = err_q;
        prog_d  = prog_q;

        unique case (state_q)
            ST_IDLE: begin
                // clr outranks run, run outranks load; losers are simply dropped.
                if (clr_p) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (run_p) begin
                    if (count_q != '0) begin
                        state_d = ST_EXEC;
                        acc_d   = A_in;
                        idx_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (load_p) begin
                    if (count_q == CNT_W'(PROG_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        prog_d[count_q[IDX_W-1:0]] = '{op: S_in, imm: B_in};
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                acc_d   = alu_out;
                flags_d = alu_flags;
                if ({1'b0, idx_q} == count_q - 1'b1) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && load_p) begin
            err_d = 1'b1;
        end
    end

    assign alu_A = acc_q;
    assign alu_B = prog_q[idx_q].imm;
    assign alu_S = prog_q[idx_q].op;
    assign acc   = acc_q;
    assign flags = flags_q;
    assign count = count_q;
    assign busy  = (state_q == ST_EXEC) || (state_q == ST_WRITE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with an in-bench ALU and result scoreboard
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_btn = 1'b0, run_btn = 1'b0, clr_btn = 1'b0;
    logic [2:0] A_in = '0, B_in = '0, S_in = '0;
    logic [2:0] alu_A, alu_B, alu_S, alu_out;
    logic [3:0] alu_flags;
    logic [2:0] acc;
    logic [3:0] flags;
    logic [2:0] count;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [6:0] sb_q [$];
    logic [2:0] sh_op [4];
    logic [2:0] sh_imm [4];
    int         sh_count = 0;
    logic [2:0] acc_trace [41];
    int         last_cycles;

    always #5 clk = ~clk;

    // Returns {N, V, C, Z, result}.
    function automatic logic [6:0] ref_alu(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
        logic [3:0] w;
        logic [2:0] r;
        logic       v;
        v = 1'b0;
        case (s)
            3'b000: begin w = {1'b0, a} + {1'b0, b}; v = (a[2] == b[2]) && (w[2] != a[2]); end
            3'b001: begin w = {1'b0, a} - {1'b0, b}; v = (a[2] != b[2]) && (w[2] != a[2]); end
            3'b010: w = {1'b0, a & b};
            3'b011: w = {1'b0, a | b};
            3'b100: w = {1'b0, a ^ b};
            default: w = {1'b0, b};
        endcase
        r = w[2:0];
        return {r[2], v, w[3], (r == 3'd0), r};
    endfunction

    assign {alu_flags, alu_out} = ref_alu(alu_A, alu_B, alu_S);

    alu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .load_btn(load_btn), .run_btn(run_btn), .clr_btn(clr_btn),
        .A_in(A_in), .B_in(B_in), .S_in(S_in),
        .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .acc(acc), .flags(flags), .count(count),
        .busy(busy), .done(done), .err(err)
    );

    task automatic press(input logic l, input logic r, input logic c);
        @(negedge clk);
        load_btn = l; run_btn = r; clr_btn = c;
        @(negedge clk);
        load_btn = 1'b0; run_btn = 1'b0; clr_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [2:0] s, input logic [2:0] b);
        S_in = s; B_in = b;
        press(1'b1, 1'b0, 1'b0);
        if (sh_count < 4) begin
            sh_op[sh_count] = s; sh_imm[sh_count] = b; sh_count++;
        end
    endtask

    task automatic do_clr();
        press(1'b0, 1'b0, 1'b1);
        sh_count = 0;
    endtask

    task automatic run_program(input logic [2:0] a);
        logic [6:0] r;
        logic [6:0] exp_v;
        logic [2:0] ea;
        logic [3:0] ef;
        int         seen;
        ea = a; ef = '0;
        for (int i = 0; i < sh_count; i++) begin
            r  = ref_alu(ea, sh_imm[i], sh_op[i]);
            ea = r[2:0];
            ef = r[6:3];
        end
        sb_q.push_back({ef, ea});
        A_in = a;
        @(negedge clk); run_btn = 1'b1;
        @(posedge clk);
        @(negedge clk); run_btn = 1'b0;
        seen = 0; last_cycles = 0;
        for (int n = 1; n <= 40 && seen == 0; n++) begin
            @(posedge clk); #1;
            acc_trace[n] = acc;
            if (done) begin seen = 1; last_cycles = n; end
        end
        exp_v = sb_q.pop_front();
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL run_timeout done not seen within 40 cycles, required by cycle %0d", 2*sh_count+1);
        end else begin
            checks++;
            if (last_cycles !== 2*sh_count+1) begin
                errors++; $display("FAIL run_latency got %0d cycles, required %0d", last_cycles, 2*sh_count+1);
            end
            if (acc !== exp_v[2:0]) begin
                errors++; $display("FAIL run_acc got %0d, required %0d", acc, exp_v[2:0]);
            end
            checks++;
            if (flags !== exp_v[6:3]) begin
                errors++; $display("FAIL run_flags got %b, required %b", flags, exp_v[6:3]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL done_width done=%b busy=%b after DONE, required 0/0", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({acc, flags, count, busy, done, err, alu_A} !== 16'd0) begin
            errors++; $display("FAIL reset_outputs got %h, required 0", {acc, flags, count, busy, done, err, alu_A});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({acc, flags, count, busy, done, err} !== 13'd0) begin
            errors++; $display("FAIL reset_release got %h, required 0", {acc, flags, count, busy, done, err});
        end
    endtask

    task automatic test_add_program();
        do_clr();
        do_load(3'b000, 3'd2);
        do_load(3'b000, 3'd3);
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL add_count got %0d, required 2", count); end
        run_program(3'd1);
        checks++;
        if (acc_trace[3] !== 3'd3) begin errors++; $display("FAIL add_first_acc got %0d, required 3", acc_trace[3]); end
        checks++;
        if (acc !== 3'd6 || flags[0] !== 1'b0) begin
            errors++; $display("FAIL add_final acc=%0d zero=%b, required 6/0", acc, flags[0]);
        end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 4; i++) do_load(3'b000, 3'(i));
        checks++;
        if (count !== 3'd4 || err !== 1'b0) begin
            errors++; $display("FAIL full_no_err count=%0d err=%b, required 4/0", count, err);
        end
        do_load(3'b001, 3'd7);
        checks++;
        if (count !== 3'd4 || err !== 1'b1) begin
            errors++; $display("FAIL overflow count=%0d err=%b, required 4/1", count, err);
        end
        do_clr();
        checks++;
        if (count !== 3'd0 || err !== 1'b0) begin
            errors++; $display("FAIL clear count=%0d err=%b, required 0/0", count, err);
        end
    endtask

    task automatic test_empty_run();
        int dones;
        int busies;
        do_clr();
        dones = 0; busies = 0;
        @(negedge clk); run_btn = 1'b1;
        @(negedge clk); run_btn = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        checks++;
        if (err !== 1'b1 || dones !== 0 || busies !== 0) begin
            errors++; $display("FAIL empty_run err=%b dones=%0d busy_cycles=%0d, required 1/0/0", err, dones, busies);
        end
    endtask

    task automatic test_carry();
        do_clr();
        do_load(3'b000, 3'd7);
        run_program(3'd1);
        checks++;
        if (acc !== 3'd0 || flags[0] !== 1'b1 || flags[1] !== 1'b1) begin
            errors++; $display("FAIL carry acc=%0d flags=%b, required acc 0 with Zero and C_Out set", acc, flags);
        end
    endtask

    task automatic test_random_programs();
        int n;
        for (int t = 0; t < 4; t++) begin
            do_clr();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) do_load(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            run_program(3'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_priority();
        int dones;
        do_clr();
        do_load(3'b000, 3'd1);
        do_load(3'b000, 3'd1);
        S_in = 3'b000; B_in = 3'd5;
        press(1'b1, 1'b0, 1'b1);
        sh_count = 0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL prio_clr_load count=%0d, required 0", count); end
        do_load(3'b000, 3'd1);
        dones = 0;
        @(negedge clk); run_btn = 1'b1; load_btn = 1'b1;
        @(negedge clk); run_btn = 1'b0; load_btn = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (done) dones++; end
        checks++;
        if (dones !== 1 || count !== 3'd1 || err !== 1'b0) begin
            errors++; $display("FAIL prio_run_load dones=%0d count=%0d err=%b, required 1/1/0", dones, count, err);
        end
        dones = 0;
        @(negedge clk); run_btn = 1'b1; clr_btn = 1'b1;
        @(negedge clk); run_btn = 1'b0; clr_btn = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (done) dones++; end
        sh_count = 0;
        checks++;
        if (dones !== 0 || count !== 3'd0) begin
            errors++; $display("FAIL prio_clr_run dones=%0d count=%0d, required 0/0", dones, count);
        end
    endtask

    task automatic test_busy_load();
        do_clr();
        do_load(3'b000, 3'd1);
        do_load(3'b000, 3'd1);
        @(negedge clk); run_btn = 1'b1;
        @(negedge clk); run_btn = 1'b0;
        @(negedge clk); load_btn = 1'b1;
        @(negedge clk); load_btn = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (err !== 1'b1 || count !== 3'd2) begin
            errors++; $display("FAIL busy_load err=%b count=%0d, required 1/2", err, count);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        do_clr();
        for (int i = 0; i < 3; i++) do_load(3'b000, 3'd1);
        A_in = 3'd2;
        @(negedge clk); run_btn = 1'b1;
        @(posedge clk);
        @(negedge clk); run_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || acc !== 3'd3) begin
            errors++; $display("FAIL abort_precond busy=%b acc=%0d, required 1/3", busy, acc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc, flags, count, busy, done, err, alu_A} !== 16'd0) begin
            errors++; $display("FAIL abort_outputs got %h, required 0", {acc, flags, count, busy, done, err, alu_A});
        end
        sh_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (done || busy) dones++; end
        checks++;
        if (dones !== 0 || count !== 3'd0) begin
            errors++; $display("FAIL abort_no_done active_cycles=%0d count=%0d, required 0/0", dones, count);
        end
    endtask

    task automatic test_held_run();
        int dones;
        do_clr();
        do_load(3'b000, 3'd1);
        dones = 0;
        @(negedge clk); run_btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 9) run_btn = 1'b0;
            if (done) dones++;
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL held_run done_pulses=%0d, required 1", dones); end
    endtask

    initial begin
        test_reset();
        test_add_program();
        test_overflow();
        test_empty_run();
        test_carry();
        test_random_programs();
        test_priority();
        test_busy_load();
        test_reset_abort();
        test_held_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
